// File: rtl/led_color_decoder_if.sv
// led_color_decoder_if
// Bundles the monitored LED drive lines and the decoder's result signals.
//   led_r/led_g/led_b : PWM drive lines being monitored (driven by the LED path)
//   color             : last legally decoded colour code (0 RED, 1 YELLOW, 2 GREEN, 3 OFF)
//   color_valid       : one-cycle pulse, a window result is available
//   err               : one-cycle pulse with color_valid, pattern was illegal
//   locked            : level, two consecutive windows decoded the same legal colour
// master = side that drives the LED lines and reads results; slave = the decoder.
interface led_color_decoder_if;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic [1:0] color;
    logic       color_valid;
    logic       err;
    logic       locked;

    modport master (
        output led_r, led_g, led_b,
        input  color, color_valid, err, locked
    );

    modport slave (
        input  led_r, led_g, led_b,
        output color, color_valid, err, locked
    );
endinterface

// File: rtl/led_color_decoder.sv
// led_color_decoder
// Loopback checker for the RGB LED PWM path. Each line is synchronised, its
// high time is counted over a free-running window of exactly PWM_PERIOD
// cycles, each count is classified (ZERO/LOW/HIGH/BAD) and the three classes
// are decoded back to a 2-bit colour code.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : led_color_decoder_if.slave (LED lines in, colour/valid/err/locked out)
module led_color_decoder #(
    parameter int PWM_PERIOD = 4096,
    parameter int CNT_W      = $clog2(PWM_PERIOD + 1),
    parameter int TH_LOW     = PWM_PERIOD / 16,
    parameter int TH_HIGH    = 3 * PWM_PERIOD / 16,
    parameter int TH_MAX     = 3 * PWM_PERIOD / 8
) (
    input  logic                clk,
    input  logic                rst,
    led_color_decoder_if.slave  bus
);

    localparam int WIN_W = $clog2(PWM_PERIOD);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] TH_LOW_C  = CNT_W'(TH_LOW);
    localparam logic [CNT_W-1:0] TH_HIGH_C = CNT_W'(TH_HIGH);
    localparam logic [CNT_W-1:0] TH_MAX_C  = CNT_W'(TH_MAX);

    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_LOW  = 2'd1;
    localparam logic [1:0] CLS_HIGH = 2'd2;
    localparam logic [1:0] CLS_BAD  = 2'd3;

    localparam logic [1:0] COLOR_OFF = 2'd3;

    // bit 0 = red, bit 1 = green, bit 2 = blue
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q [3];
    logic [CNT_W-1:0] hi_cnt_d [3];
    logic [CNT_W-1:0] snap_q [3];
    logic [CNT_W-1:0] snap_d [3];
    logic             snap_ld_q, snap_ld_d;
    logic [1:0]       color_q, color_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic             prev_ok_q, prev_ok_d;

    logic             win_last;
    logic [CNT_W-1:0] hi_sum [3];
    logic [1:0]       cls_r, cls_g, cls_b;
    logic             legal;
    logic [1:0]       code;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] v);
        if (v < TH_LOW_C)       return CLS_ZERO;
        else if (v < TH_HIGH_C) return CLS_LOW;
        else if (v < TH_MAX_C)  return CLS_HIGH;
        else                    return CLS_BAD;
    endfunction

    always_comb begin
        sync1_d   = {bus.led_b, bus.led_g, bus.led_r};
        sync2_d   = sync1_q;
        win_last  = (win_cnt_q == WIN_LAST);
        win_cnt_d = win_last ? '0 : win_cnt_q + WIN_W'(1);
        // snapshot is loaded on the window's last edge; result is published one edge later
        snap_ld_d = win_last;

        for (int i = 0; i < 3; i++) begin
            // the sample taken on the last edge belongs to the closing window
            hi_sum[i] = hi_cnt_q[i] + CNT_W'(sync2_q[i]);
            if (win_last) begin
                snap_d[i]   = hi_sum[i];
                hi_cnt_d[i] = '0;
            end else begin
                snap_d[i]   = snap_q[i];
                hi_cnt_d[i] = hi_sum[i];
            end
        end

        cls_r = classify(snap_q[0]);
        cls_g = classify(snap_q[1]);
        cls_b = classify(snap_q[2]);

        legal = 1'b1;
        code  = COLOR_OFF;
        case ({cls_r, cls_g, cls_b})
            {CLS_HIGH, CLS_ZERO, CLS_ZERO}: code = 2'd0;
            {CLS_LOW,  CLS_LOW,  CLS_ZERO}: code = 2'd1;
            {CLS_ZERO, CLS_HIGH, CLS_ZERO}: code = 2'd2;
            {CLS_ZERO, CLS_ZERO, CLS_ZERO}: code = 2'd3;
            default:                        legal = 1'b0;
        endcase

        valid_d   = snap_ld_q;
        err_d     = snap_ld_q & ~legal;
        color_d   = color_q;
        locked_d  = locked_q;
        prev_ok_d = prev_ok_q;
        if (snap_ld_q) begin
            if (legal) begin
                // color_q still holds the previous window's code when prev_ok_q is set
                locked_d  = prev_ok_q && (code == color_q);
                color_d   = code;
                prev_ok_d = 1'b1;
            end else begin
                locked_d  = 1'b0;
                prev_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            win_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                hi_cnt_q[i] <= '0;
                snap_q[i]   <= '0;
            end
            snap_ld_q <= 1'b0;
            color_q   <= COLOR_OFF;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            prev_ok_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            win_cnt_q <= win_cnt_d;
            for (int i = 0; i < 3; i++) begin
                hi_cnt_q[i] <= hi_cnt_d[i];
                snap_q[i]   <= snap_d[i];
            end
            snap_ld_q <= snap_ld_d;
            color_q   <= color_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            prev_ok_q <= prev_ok_d;
        end
    end

    assign bus.color       = color_q;
    assign bus.color_valid = valid_q;
    assign bus.err         = err_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_led_color_decoder.sv
module tb_led_color_decoder;

    localparam int P = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_color_decoder_if bus();

    led_color_decoder #(.PWM_PERIOD(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PWM line generator: each line high for du cycles out of every P, rotated by ph
    int pc   = 0;
    int du_r = 0, ph_r = 0, du_g = 0, ph_g = 0, du_b = 0, ph_b = 0;
    bit tog  = 1'b0;
    bit r_lvl = 1'b0;

    function automatic bit pwm_on(input int c, input int ph, input int du);
        return (((c - ph + P) % P) < du);
    endfunction

    always @(negedge clk) begin
        pc = (pc + 1) % P;
        if (tog) r_lvl = ~r_lvl;
        else     r_lvl = pwm_on(pc, ph_r, du_r);
        bus.led_r = r_lvl;
        bus.led_g = pwm_on(pc, ph_g, du_g);
        bus.led_b = pwm_on(pc, ph_b, du_b);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // returns number of posedges until color_valid is seen (0 on timeout)
    task automatic wait_valid(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 3 * P; i++) begin
            @(posedge clk);
            #1;
            if (bus.color_valid) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: color_valid timeout, got none within %0d cycles", name, 3 * P);
        end
    endtask

    typedef struct {
        int dr, pr, dg, pg, db, pb;
        int code;
        bit e;
    } vec_t;

    vec_t vt [18];

    int  n;
    int  last_color;
    bit  prev_legal;
    int  prev_code;
    int  exp_col;
    int  exp_lck;

    initial begin
        vt[0]  = '{0,  0,  0,  0,  0, 0, 3, 1'b0};
        vt[1]  = '{16, 7,  0,  0,  0, 0, 0, 1'b0};
        vt[2]  = '{0,  0,  0,  0, 16, 9, 0, 1'b1};
        vt[3]  = '{8,  0,  8, 30,  0, 0, 1, 1'b0};
        vt[4]  = '{0,  0, 16, 50,  0, 0, 2, 1'b0};
        vt[5]  = '{3, 61,  0,  0,  0, 0, 3, 1'b0};
        vt[6]  = '{4, 62,  0,  0,  0, 0, 0, 1'b1};
        vt[7]  = '{11, 5,  0,  0,  0, 0, 0, 1'b1};
        vt[8]  = '{12, 40, 0,  0,  0, 0, 0, 1'b0};
        vt[9]  = '{23, 13, 0,  0,  0, 0, 0, 1'b0};
        vt[10] = '{24, 2,  0,  0,  0, 0, 0, 1'b1};
        vt[11] = '{64, 0,  0,  0,  0, 0, 0, 1'b1};
        vt[12] = '{0,  0, 12, 20,  0, 0, 2, 1'b0};
        vt[13] = '{0,  0, 11, 33,  0, 0, 0, 1'b1};
        vt[14] = '{16, 0, 16, 10,  0, 0, 0, 1'b1};
        vt[15] = '{8,  3,  8,  3,  8, 3, 0, 1'b1};
        vt[16] = '{8, 44,  8, 12,  0, 0, 1, 1'b0};
        vt[17] = '{0,  0,  0,  0,  0, 0, 3, 1'b0};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_color", bus.color, 3);
        chk("rst_valid", bus.color_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // reach a RED-locked state, then reset asynchronously mid-window with red toggling
        du_r = 16; ph_r = 21;
        for (int k = 0; k < 3; k++) wait_valid("pre_rst", n);
        chk("pre_rst_color", bus.color, 0);
        chk("pre_rst_locked", bus.locked, 1);
        du_r = 0;
        tog  = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_color", bus.color, 3);
        chk("async_rst_valid", bus.color_valid, 0);
        chk("async_rst_err", bus.err, 0);
        chk("async_rst_locked", bus.locked, 0);
        repeat (3) @(posedge clk);
        #1;
        tog = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // first result after release, then one-cycle pulse width and period
        wait_valid("first_valid", n);
        chk("first_valid_cycle", n, P + 1);
        chk("first_color", bus.color, 3);
        chk("first_err", bus.err, 0);
        @(posedge clk);
        #1;
        chk("valid_width", bus.color_valid, 0);
        wait_valid("period", n);
        chk("valid_period", n + 1, P);

        last_color = 3;
        prev_legal = 1'b1;
        prev_code  = 3;

        for (int i = 0; i < 18; i++) begin
            // switch pattern so the new one fills a whole window exactly
            wait_valid("align", n);
            repeat (P - 3) @(posedge clk);
            #1;
            du_r = vt[i].dr; ph_r = vt[i].pr;
            du_g = vt[i].dg; ph_g = vt[i].pg;
            du_b = vt[i].db; ph_b = vt[i].pb;
            wait_valid("old_win", n);

            exp_col = vt[i].e ? last_color : vt[i].code;
            exp_lck = (!vt[i].e && prev_legal && prev_code == vt[i].code) ? 1 : 0;
            wait_valid("win1", n);
            chk($sformatf("v%0d_win1_color", i), bus.color, exp_col);
            chk($sformatf("v%0d_win1_err", i), bus.err, vt[i].e);
            chk($sformatf("v%0d_win1_locked", i), bus.locked, exp_lck);
            if (!vt[i].e) last_color = vt[i].code;

            wait_valid("win2", n);
            chk($sformatf("v%0d_win2_color", i), bus.color, last_color);
            chk($sformatf("v%0d_win2_err", i), bus.err, vt[i].e);
            chk($sformatf("v%0d_win2_locked", i), bus.locked, vt[i].e ? 0 : 1);
            prev_legal = !vt[i].e;
            prev_code  = vt[i].code;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
